// File: rtl/insmem_pkg.sv
// insmem_pkg: shared defaults and FSM state encoding for the instruction
// memory controller.
//   PC_BITS_DEF / INSTR_W_DEF : default address and instruction widths
//   state_e                   : controller state (IDLE / LOAD / DONE)
package insmem_pkg;

    localparam int PC_BITS_DEF = 6;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/insmem_ctrl.sv
// insmem_ctrl: arbitrates the single-port instruction memory between the boot
// loader write stream and fetch read requests.
//   clka, rst_n            : clock (rising edge), async active-low reset
//   load_start/valid/last  : loader control; load_data is the word to write
//   load_ready/done/count  : loader handshake, end pulse, words written
//   fetch_req/pc           : read request; fetch_ready acknowledges it
//   fetch_valid/instr      : read return, one cycle after acceptance
//   mem_we/pc/din, mem_dout: memory pins (mem_dout registered inside memory)
//   busy                   : high while loading or signalling completion
module insmem_ctrl
    import insmem_pkg::*;
#(
    parameter int PC_BITS = PC_BITS_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clka,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic               load_last,
    input  logic [INSTR_W-1:0] load_data,
    output logic               load_ready,
    output logic               load_done,
    output logic [PC_BITS:0]   load_count,
    input  logic               fetch_req,
    input  logic [PC_BITS-1:0] fetch_pc,
    output logic               fetch_ready,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               mem_we,
    output logic [PC_BITS-1:0] mem_pc,
    output logic [INSTR_W-1:0] mem_din,
    input  logic [INSTR_W-1:0] mem_dout,
    output logic               busy
);

    localparam logic [PC_BITS-1:0] LAST_ADDR = {PC_BITS{1'b1}};

    state_e             state_q, state_d;
    logic [PC_BITS-1:0] wptr_q, wptr_d;
    logic [PC_BITS:0]   count_q, count_d;
    logic               load_ready_q, load_ready_d;
    logic               load_done_q, load_done_d;
    logic               busy_q, busy_d;
    logic               fetch_valid_q, fetch_valid_d;

    logic               wr_fire;
    logic               rd_fire;

    // Fetch is only offered in IDLE and loses to a same-cycle load_start.
    // rst_n gating keeps the combinational outputs at zero during reset.
    assign fetch_ready = rst_n && (state_q == ST_IDLE) && !load_start;
    assign rd_fire     = fetch_ready && fetch_req;
    assign wr_fire     = load_valid && load_ready_q;

    // Address mux: write and read issue are mutually exclusive by state.
    assign mem_we  = wr_fire;
    assign mem_pc  = wr_fire ? wptr_q : (rd_fire ? fetch_pc : '0);
    assign mem_din = wr_fire ? load_data : '0;

    // Memory output is already registered, so the return path only tracks
    // which cycle holds a requested word.
    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_valid_q ? mem_dout : '0;

    assign load_ready = load_ready_q;
    assign load_done  = load_done_q;
    assign load_count = count_q;
    assign busy       = busy_q;

    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        count_d       = count_q;
        fetch_valid_d = rd_fire;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                if (wr_fire) begin
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    // Stop on the final word or when the top address is filled.
                    if (load_last || (wptr_q == LAST_ADDR)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Status outputs are registered copies of the next-state decode.
        load_ready_d = (state_d == ST_LOAD);
        load_done_d  = (state_d == ST_DONE);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_DONE);
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wptr_q        <= '0;
            count_q       <= '0;
            load_ready_q  <= 1'b0;
            load_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            count_q       <= count_d;
            load_ready_q  <= load_ready_d;
            load_done_q   <= load_done_d;
            busy_q        <= busy_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

endmodule

// File: tb/tb_insmem_ctrl.sv
// tb_insmem_ctrl: self-checking bench for insmem_ctrl with a registered-read
// memory model, a vector table and a fetch-return scoreboard.
module tb_insmem_ctrl;

    localparam int PCB   = 6;
    localparam int IW    = 16;
    localparam int DEPTH = 64;

    logic            clka = 1'b0;
    logic            rst_n;
    logic            load_start, load_valid, load_last;
    logic [IW-1:0]   load_data;
    logic            load_ready, load_done;
    logic [PCB:0]    load_count;
    logic            fetch_req;
    logic [PCB-1:0]  fetch_pc;
    logic            fetch_ready, fetch_valid;
    logic [IW-1:0]   fetch_instr;
    logic            mem_we;
    logic [PCB-1:0]  mem_pc;
    logic [IW-1:0]   mem_din;
    logic [IW-1:0]   mem_dout;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clka = ~clka;
    always @(posedge clka) cyc <= cyc + 1;

    insmem_ctrl #(.PC_BITS(PCB), .INSTR_W(IW)) dut (
        .clka(clka), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
        .load_count(load_count), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .mem_we(mem_we), .mem_pc(mem_pc),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    // Memory model: registered read, unwritten words return a fixed pattern.
    function automatic logic [IW-1:0] init_word(int a);
        return 16'hC000 + 16'(a * 7);
    endfunction

    logic [IW-1:0] mem [DEPTH];
    bit            written [DEPTH];
    always @(posedge clka) begin
        if (mem_we) begin
            mem[mem_pc]     <= mem_din;
            written[mem_pc] <= 1'b1;
        end
        mem_dout <= written[mem_pc] ? mem[mem_pc] : init_word(int'(mem_pc));
    end

    logic [IW-1:0] exp_mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each accepted fetch must return exactly one cycle later.
    typedef struct { logic [IW-1:0] d; int c; } sb_t;
    sb_t sbq[$];

    always @(negedge clka) begin
        if (rst_n) begin
            if (sbq.size() > 0 && sbq[0].c == cyc - 1) begin
                chk("fetch_valid", 32'(fetch_valid), 32'd1);
                chk("fetch_instr", 32'(fetch_instr), 32'(sbq[0].d));
                void'(sbq.pop_front());
            end else if (fetch_valid) begin
                chk("unexpected_fetch_valid", 32'(fetch_valid), 32'd0);
            end
        end
    end

    typedef struct {
        logic ls, lv, ll; logic [IW-1:0] ld; logic fq; logic [PCB-1:0] fpc;
        logic e_lr, e_fr, e_we; logic [PCB-1:0] e_pc; logic e_busy, e_done;
        logic [PCB:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic ls, logic lv, logic ll, logic [IW-1:0] ld,
                                logic fq, logic [PCB-1:0] fpc, logic e_lr, logic e_fr,
                                logic e_we, logic [PCB-1:0] e_pc, logic e_busy,
                                logic e_done, logic [PCB:0] e_cnt);
        vec_t v;
        v.ls = ls; v.lv = lv; v.ll = ll; v.ld = ld; v.fq = fq; v.fpc = fpc;
        v.e_lr = e_lr; v.e_fr = e_fr; v.e_we = e_we; v.e_pc = e_pc;
        v.e_busy = e_busy; v.e_done = e_done; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic idle_inputs();
        load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        fetch_req = 0; fetch_pc = '0;
    endtask

    // Drive a row, check at the falling edge, advance past the next rising edge.
    task automatic apply_row(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("row%0d", idx);
        load_start = v.ls; load_valid = v.lv; load_last = v.ll; load_data = v.ld;
        fetch_req = v.fq; fetch_pc = v.fpc;
        @(negedge clka);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'(v.e_lr));
        chk({tag, "_fetch_ready"}, 32'(fetch_ready), 32'(v.e_fr));
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(v.e_we));
        if (v.e_we || (v.e_fr && v.fq)) chk({tag, "_mem_pc"}, 32'(mem_pc), 32'(v.e_pc));
        if (v.e_we) begin
            chk({tag, "_mem_din"}, 32'(mem_din), 32'(v.ld));
            exp_mem[v.e_pc] = v.ld;
        end
        chk({tag, "_busy"}, 32'(busy), 32'(v.e_busy));
        chk({tag, "_load_done"}, 32'(load_done), 32'(v.e_done));
        chk({tag, "_load_count"}, 32'(load_count), 32'(v.e_cnt));
        if (v.e_fr && v.fq) sbq.push_back('{d: exp_mem[v.fpc], c: cyc});
        @(posedge clka); #1;
    endtask

    task automatic do_fetch(input logic [PCB-1:0] pc);
        fetch_req = 1; fetch_pc = pc;
        @(negedge clka);
        chk("fetch_ready", 32'(fetch_ready), 32'd1);
        chk("fetch_mem_pc", 32'(mem_pc), 32'(pc));
        chk("fetch_mem_we", 32'(mem_we), 32'd0);
        sbq.push_back('{d: exp_mem[pc], c: cyc});
        @(posedge clka); #1;
        fetch_req = 0;
    endtask

    vec_t tbl[14];

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);
        idle_inputs();
        rst_n = 0;
        #3;
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_instr", 32'(fetch_instr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_pc", 32'(mem_pc), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clka); @(posedge clka); #1;
        rst_n = 1;

        // ls lv ll data     fq pc | lr fr we pc busy done cnt
        tbl[0]  = mk(0, 0, 0, 16'h0000, 1, 5, 0, 1, 0, 5, 0, 0, 0); // idle fetch
        tbl[1]  = mk(1, 0, 0, 16'h0000, 1, 7, 0, 0, 0, 0, 0, 0, 0); // start beats fetch
        tbl[2]  = mk(0, 1, 0, 16'h1111, 1, 7, 1, 0, 1, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 1, 0, 1); // bubble
        tbl[4]  = mk(1, 1, 0, 16'h2222, 0, 0, 1, 0, 1, 1, 1, 0, 1); // start ignored
        tbl[5]  = mk(0, 1, 1, 16'h3333, 0, 0, 1, 0, 1, 2, 1, 0, 2); // last word
        tbl[6]  = mk(1, 1, 0, 16'hDEAD, 1, 3, 0, 0, 0, 0, 1, 1, 3); // DONE ignores all
        tbl[7]  = mk(0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 0, 3);
        tbl[8]  = mk(0, 0, 0, 16'h0000, 1, 1, 0, 1, 0, 1, 0, 0, 3);
        tbl[9]  = mk(0, 0, 0, 16'h0000, 1, 2, 0, 1, 0, 2, 0, 0, 3);
        tbl[10] = mk(0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 0, 3); // pipelined 0,2,4,6
        tbl[11] = mk(0, 0, 0, 16'h0000, 1, 2, 0, 1, 0, 2, 0, 0, 3);
        tbl[12] = mk(0, 0, 0, 16'h0000, 1, 4, 0, 1, 0, 4, 0, 0, 3);
        tbl[13] = mk(0, 0, 0, 16'h0000, 1, 6, 0, 1, 0, 6, 0, 0, 3);
        for (int i = 0; i < 14; i++) apply_row(tbl[i], i);
        idle_inputs();
        @(posedge clka); #1;

        // Full load: 64 words without load_last, then a refused 65th word.
        load_start = 1;
        @(posedge clka); #1;
        load_start = 0;
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1; load_data = 16'(i);
            @(negedge clka);
            chk("full_ready", 32'(load_ready), 32'd1);
            chk("full_we", 32'(mem_we), 32'd1);
            chk("full_pc", 32'(mem_pc), 32'(i));
            exp_mem[i] = 16'(i);
            @(posedge clka); #1;
        end
        load_data = 16'hBEEF;
        @(negedge clka);
        chk("full_65_ready", 32'(load_ready), 32'd0);
        chk("full_65_we", 32'(mem_we), 32'd0);
        chk("full_done", 32'(load_done), 32'd1);
        chk("full_count", 32'(load_count), 32'd64);
        @(posedge clka); #1;
        load_valid = 0;
        @(negedge clka);
        chk("full_done_pulse", 32'(load_done), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_count_hold", 32'(load_count), 32'd64);
        @(posedge clka); #1;
        do_fetch(63);
        do_fetch(0);
        @(posedge clka); #1;

        // Reset in the middle of a load.
        load_start = 1;
        @(posedge clka); #1;
        load_start = 0; load_valid = 1;
        for (int i = 0; i < 2; i++) begin
            load_data = 16'hA0A0 + 16'(i);
            @(negedge clka);
            chk("mid_we", 32'(mem_we), 32'd1);
            exp_mem[i] = load_data;
            @(posedge clka); #1;
        end
        load_data = 16'hA2A2;
        #1 rst_n = 0;
        #1;
        chk("mid_rst_ready", 32'(load_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_pc", 32'(mem_pc), 32'd0);
        chk("mid_rst_din", 32'(mem_din), 32'd0);
        chk("mid_rst_count", 32'(load_count), 32'd0);
        @(posedge clka); #1;
        rst_n = 1;
        idle_inputs();
        @(negedge clka);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("post_rst_count", 32'(load_count), 32'd0);
        @(posedge clka); #1;
        do_fetch(0);
        do_fetch(1);
        do_fetch(2);
        @(posedge clka); #1;
        @(posedge clka); #1;

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
